// File: rtl/uart_cmd_rx.sv
// UART 8N1 receiver with ASCII command parser for the temperature monitor.
// Accepts "Hdddd" (threshold, degC x100) and "Pd" (report period) lines.
module uart_cmd_rx #(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        frame_err,
    output logic        cmd_ok,
    output logic        cmd_err,
    output logic [15:0] thr_x100,
    output logic [3:0]  period_s
);

    localparam int unsigned CPB  = CLK_HZ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB + 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;

    typedef enum logic [2:0] {
        R_IDLE, R_START, R_DATA, R_STOP, R_BREAK
    } rstate_e;

    typedef enum logic [1:0] {
        P_IDLE, P_HDIG, P_PDIG, P_TERM
    } pstate_e;

    logic          s1_q, s2_q;
    logic          armed_q, armed_d;
    rstate_e       rs_q, rs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [7:0]    data_q, data_d;
    logic          rxv_q, rxv_d;
    logic          ferr_q, ferr_d;

    pstate_e       ps_q, ps_d;
    logic [13:0]   acc_q, acc_d;
    logic [2:0]    n_q, n_d;
    logic [3:0]    pend_q, pend_d;
    logic [15:0]   thr_q, thr_d;
    logic [3:0]    per_q, per_d;
    logic          ok_q, ok_d;
    logic          err_q, err_d;

    logic          is_term, is_dig, is_h, is_p;
    logic [3:0]    dig;

    always_comb begin
        rs_d    = rs_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        rxv_d   = 1'b0;
        ferr_d  = 1'b0;
        armed_d = armed_q | s2_q;
        unique case (rs_q)
            R_IDLE: begin
                if (armed_q && !s2_q) begin
                    rs_d  = R_START;
                    cnt_d = '0;
                    bit_d = '0;
                end
            end
            R_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    rs_d  = s2_q ? R_IDLE : R_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_DATA: begin
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    sh_d  = {s2_q, sh_q[7:1]};
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) rs_d = R_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_STOP: begin
                // Leaving at the stop-bit centre lets a back-to-back start be caught.
                if (cnt_q == CPB_M1) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        data_d = sh_q;
                        rxv_d  = 1'b1;
                        rs_d   = R_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                        rs_d    = R_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            R_BREAK: begin
                if (s2_q) rs_d = R_IDLE;
            end
            default: rs_d = R_IDLE;
        endcase
    end

    assign is_term = (data_q == CH_CR) || (data_q == CH_LF);
    assign is_dig  = (data_q >= CH_0) && (data_q <= CH_9);
    assign is_h    = (data_q == 8'h48) || (data_q == 8'h68);
    assign is_p    = (data_q == 8'h50) || (data_q == 8'h70);
    assign dig     = data_q[3:0];

    always_comb begin
        ps_d   = ps_q;
        acc_d  = acc_q;
        n_d    = n_q;
        pend_d = pend_q;
        thr_d  = thr_q;
        per_d  = per_q;
        ok_d   = 1'b0;
        err_d  = 1'b0;
        if (ferr_q) begin
            if (ps_q != P_IDLE) begin
                err_d = 1'b1;
                ps_d  = P_IDLE;
            end
        end else if (rxv_q) begin
            unique case (ps_q)
                P_IDLE: begin
                    if (is_h) begin
                        ps_d  = P_HDIG;
                        acc_d = '0;
                        n_d   = '0;
                    end else if (is_p) begin
                        ps_d = P_PDIG;
                    end else if (!is_term) begin
                        err_d = 1'b1;
                    end
                end
                P_HDIG: begin
                    if (is_dig && n_q != 3'd4) begin
                        acc_d = acc_q * 14'd10 + {10'd0, dig};
                        n_d   = n_q + 3'd1;
                    end else if (is_term && n_q == 3'd4) begin
                        thr_d = {2'b00, acc_q};
                        ok_d  = 1'b1;
                        ps_d  = P_IDLE;
                    end else begin
                        err_d = 1'b1;
                        ps_d  = P_IDLE;
                    end
                end
                P_PDIG: begin
                    if (is_dig && dig != 4'd0) begin
                        pend_d = dig;
                        ps_d   = P_TERM;
                    end else begin
                        err_d = 1'b1;
                        ps_d  = P_IDLE;
                    end
                end
                P_TERM: begin
                    if (is_term) begin
                        per_d = pend_q;
                        ok_d  = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    ps_d = P_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            armed_q <= 1'b0;
            rs_q    <= R_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= 8'h00;
            rxv_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ps_q    <= P_IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            pend_q  <= 4'd1;
            thr_q   <= 16'd8500;
            per_q   <= 4'd1;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            s1_q    <= rx;
            s2_q    <= s1_q;
            armed_q <= armed_d;
            rs_q    <= rs_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            rxv_q   <= rxv_d;
            ferr_q  <= ferr_d;
            ps_q    <= ps_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            pend_q  <= pend_d;
            thr_q   <= thr_d;
            per_q   <= per_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = rxv_q;
    assign frame_err = ferr_q;
    assign cmd_ok    = ok_q;
    assign cmd_err   = err_q;
    assign thr_x100  = thr_q;
    assign period_s  = per_q;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: serial stimulus, line-level command model.
// Runs at 16 clocks per bit to keep frames short.
module tb_uart_cmd_rx;

    localparam int CLK_HZ = 1_600_000;
    localparam int BAUD   = 100_000;
    localparam int CPB    = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, frame_err, cmd_ok, cmd_err;
    logic [15:0] thr_x100;
    logic [3:0]  period_s;

    always #5 clk = ~clk;

    uart_cmd_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err),
        .thr_x100(thr_x100), .period_s(period_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Observed events
    int n_rxv = 0, n_ferr = 0, n_ok = 0, n_err = 0, n_viol = 0;
    logic [7:0]  rxq[$];
    logic [15:0] ok_thr = '0;
    logic [3:0]  ok_per = '0;
    bit          prev_ev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && frame_err) n_viol++;
        if (cmd_ok && cmd_err) n_viol++;
        if ((cmd_ok || cmd_err) && !prev_ev) n_viol++;
        if (rx_valid) begin
            n_rxv++;
            rxq.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
        if (cmd_ok) begin
            n_ok++;
            ok_thr = thr_x100;
            ok_per = period_s;
        end
        if (cmd_err) n_err++;
        prev_ev = rx_valid || frame_err;
    end

    // Reference model: whole-line view of the command language
    int          m_ok = 0, m_err = 0;
    logic [15:0] m_thr = 16'd8500;
    logic [3:0]  m_per = 4'd1;
    bit          col = 1'b0;
    logic [7:0]  cbuf[$];
    logic [7:0]  sent_q[$];

    function automatic bit is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        bit term, hcmd, ok;
        int v;
        term = (b == 8'h0D) || (b == 8'h0A);
        if (!col) begin
            if (term) return;
            if (b inside {8'h48, 8'h68, 8'h50, 8'h70}) begin
                col = 1'b1;
                cbuf.delete();
                cbuf.push_back(b);
            end else begin
                m_err++;
            end
            return;
        end
        hcmd = cbuf[0] inside {8'h48, 8'h68};
        if (term) begin
            col = 1'b0;
            if (hcmd && cbuf.size() == 5) begin
                v = 0;
                for (int i = 1; i < 5; i++) v = v * 10 + (cbuf[i] - 8'h30);
                m_thr = 16'(v);
                m_ok++;
            end else if (!hcmd && cbuf.size() == 2) begin
                m_per = cbuf[1][3:0];
                m_ok++;
            end else begin
                m_err++;
            end
            return;
        end
        cbuf.push_back(b);
        if (hcmd) ok = (cbuf.size() <= 5) && is_digit(b);
        else ok = (cbuf.size() == 2) && (b >= 8'h31) && (b <= 8'h39);
        if (!ok) begin
            m_err++;
            col = 1'b0;
        end
    endfunction

    function automatic void model_ferr();
        if (col) begin
            m_err++;
            col = 1'b0;
        end
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(CPB);
        end
        if (bad_stop) begin
            rx = 1'b0;
            idle(2 * CPB);
        end
        rx = 1'b1;
        idle(CPB);
        if (bad_stop) begin
            model_ferr();
        end else begin
            sent_q.push_back(b);
            model_byte(b);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
    endtask

    task automatic send_cmd(input string s, input logic [7:0] term);
        send_str(s);
        send_byte(term, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        rx  = 1'b1;
        idle(5);
        n_checks++;
        if (rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset rx_data: got %h want 00", rx_data);
        end
        n_checks++;
        if ({rx_valid, frame_err, cmd_ok, cmd_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset pulses: got %b want 0000",
                     {rx_valid, frame_err, cmd_ok, cmd_err});
        end
        n_checks++;
        if (thr_x100 !== 16'd8500) begin
            n_fail++;
            $display("FAIL reset thr: got %0d want 8500", thr_x100);
        end
        n_checks++;
        if (period_s !== 4'd1) begin
            n_fail++;
            $display("FAIL reset period: got %0d want 1", period_s);
        end
        rst = 1'b1;
        idle(4);
    endtask

    task automatic test_threshold();
        int r0;
        r0 = n_rxv;
        send_cmd("H2575", 8'h0D);
        idle(2 * CPB);
        n_checks++;
        if (n_rxv - r0 !== 6) begin
            n_fail++;
            $display("FAIL thr rx_valid count: got %0d want 6", n_rxv - r0);
        end
        n_checks++;
        if (n_ok !== m_ok) begin
            n_fail++;
            $display("FAIL thr cmd_ok: got %0d want %0d", n_ok, m_ok);
        end
        n_checks++;
        if (thr_x100 !== 16'd2575) begin
            n_fail++;
            $display("FAIL thr value: got %0d want 2575", thr_x100);
        end
        n_checks++;
        if (ok_thr !== 16'd2575) begin
            n_fail++;
            $display("FAIL thr at cmd_ok: got %0d want 2575", ok_thr);
        end
    endtask

    task automatic test_period();
        send_cmd("p5", 8'h0A);
        idle(2 * CPB);
        n_checks++;
        if (period_s !== 4'd5 || ok_per !== 4'd5) begin
            n_fail++;
            $display("FAIL period set: got %0d/%0d want 5", period_s, ok_per);
        end
        send_cmd("P0", 8'h0D);
        idle(2 * CPB);
        n_checks++;
        if (period_s !== 4'd5) begin
            n_fail++;
            $display("FAIL period kept: got %0d want 5", period_s);
        end
        n_checks++;
        if (n_err !== m_err || n_ok !== m_ok) begin
            n_fail++;
            $display("FAIL period counts: got ok %0d err %0d want ok %0d err %0d",
                     n_ok, n_err, m_ok, m_err);
        end
    endtask

    task automatic test_bad_thr();
        send_cmd("H123", 8'h0D);
        send_cmd("H12345", 8'h0D);
        idle(2 * CPB);
        n_checks++;
        if (thr_x100 !== m_thr) begin
            n_fail++;
            $display("FAIL bad thr kept: got %0d want %0d", thr_x100, m_thr);
        end
        n_checks++;
        if (n_err !== m_err || n_ok !== m_ok) begin
            n_fail++;
            $display("FAIL bad thr counts: got ok %0d err %0d want ok %0d err %0d",
                     n_ok, n_err, m_ok, m_err);
        end
    endtask

    task automatic test_frame_err();
        int r0, f0;
        r0 = n_rxv;
        f0 = n_ferr;
        send_byte(8'h48, 1'b1);
        idle(2 * CPB);
        n_checks++;
        if (n_ferr - f0 !== 1 || n_rxv !== r0) begin
            n_fail++;
            $display("FAIL frame_err: got ferr %0d rxv %0d want ferr 1 rxv 0",
                     n_ferr - f0, n_rxv - r0);
        end
        n_checks++;
        if (n_err !== m_err) begin
            n_fail++;
            $display("FAIL frame_err idle: got err %0d want %0d", n_err, m_err);
        end
        send_str("H1");
        send_byte(8'hA5, 1'b1);
        idle(2 * CPB);
        n_checks++;
        if (n_err !== m_err) begin
            n_fail++;
            $display("FAIL frame_err mid cmd: got err %0d want %0d", n_err, m_err);
        end
        send_cmd("P3", 8'h0D);
        idle(2 * CPB);
        n_checks++;
        if (period_s !== 4'd3) begin
            n_fail++;
            $display("FAIL period after ferr: got %0d want 3", period_s);
        end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = n_rxv;
        f0 = n_ferr;
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(12 * CPB);
        n_checks++;
        if (n_rxv !== r0 || n_ferr !== f0) begin
            n_fail++;
            $display("FAIL glitch: got rxv %0d ferr %0d want 0 0",
                     n_rxv - r0, n_ferr - f0);
        end
        send_byte(8'h55, 1'b0);
        idle(2 * CPB);
        n_checks++;
        if (rx_data !== 8'h55 || n_rxv - r0 !== 1) begin
            n_fail++;
            $display("FAIL after glitch: got %h x%0d want 55 x1", rx_data, n_rxv - r0);
        end
    endtask

    task automatic test_reset_midframe();
        int r0, f0;
        logic [7:0] h;
        h = 8'h48;
        send_cmd("H4321", 8'h0D);
        idle(CPB);
        r0 = n_rxv;
        f0 = n_ferr;
        rx = 1'b0;
        idle(CPB);
        for (int i = 0; i < 3; i++) begin
            rx = h[i];
            idle(CPB);
        end
        rx = h[3];
        idle(CPB / 2);
        rst = 1'b0;
        #1;
        n_checks++;
        if (thr_x100 !== 16'd8500 || period_s !== 4'd1 || rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL async reset: got thr %0d per %0d data %h want 8500 1 00",
                     thr_x100, period_s, rx_data);
        end
        idle(3);
        rx  = 1'b1;
        rst = 1'b1;
        m_thr = 16'd8500;
        m_per = 4'd1;
        col   = 1'b0;
        idle(12 * CPB);
        n_checks++;
        if (n_rxv !== r0 || n_ferr !== f0) begin
            n_fail++;
            $display("FAIL partial frame: got rxv %0d ferr %0d want 0 0",
                     n_rxv - r0, n_ferr - f0);
        end
        send_cmd("H0100", 8'h0D);
        idle(2 * CPB);
        n_checks++;
        if (thr_x100 !== 16'd100) begin
            n_fail++;
            $display("FAIL thr after reset: got %0d want 100", thr_x100);
        end
    endtask

    task automatic test_random_back_to_back();
        logic [7:0] lt;
        logic [7:0] term;
        int kind, nd;
        for (int k = 0; k < 25; k++) begin
            kind = $urandom_range(0, 5);
            lt   = ($urandom_range(0, 1) != 0) ? 8'h48 : 8'h68;
            term = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
            case (kind)
                0, 1: send_cmd($sformatf("%c%04d", lt, $urandom_range(0, 9999)), term);
                2: send_cmd($sformatf("%c%0d", lt + 8'h08, $urandom_range(1, 9)), term);
                3: begin
                    nd = $urandom_range(1, 3);
                    for (int j = 0; j < nd; j++)
                        send_byte(8'($urandom_range(0, 255)), 1'b0);
                end
                4: begin
                    send_byte(lt, 1'b0);
                    nd = $urandom_range(0, 5);
                    for (int j = 0; j < nd; j++)
                        send_byte(8'h30 + 8'($urandom_range(0, 9)), 1'b0);
                    send_byte(term, 1'b0);
                end
                default: begin
                    send_byte(lt + 8'h08, 1'b0);
                    send_byte(8'($urandom_range(32, 126)), 1'b0);
                    send_byte(term, 1'b0);
                end
            endcase
        end
        idle(2 * CPB);
        n_checks++;
        if (n_ok !== m_ok || n_err !== m_err) begin
            n_fail++;
            $display("FAIL random counts: got ok %0d err %0d want ok %0d err %0d",
                     n_ok, n_err, m_ok, m_err);
        end
        n_checks++;
        if (thr_x100 !== m_thr || period_s !== m_per) begin
            n_fail++;
            $display("FAIL random settings: got %0d/%0d want %0d/%0d",
                     thr_x100, period_s, m_thr, m_per);
        end
    endtask

    task automatic test_invariants();
        int bad;
        bad = 0;
        n_checks++;
        if (n_viol !== 0) begin
            n_fail++;
            $display("FAIL pulse rules: got %0d violations want 0", n_viol);
        end
        n_checks++;
        if (rxq.size() !== sent_q.size()) begin
            n_fail++;
            $display("FAIL byte count: got %0d want %0d", rxq.size(), sent_q.size());
        end else begin
            for (int i = 0; i < rxq.size(); i++)
                if (rxq[i] !== sent_q[i]) bad++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL byte stream: got %0d wrong bytes want 0", bad);
            end
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_period();
        test_bad_thr();
        test_frame_err();
        test_glitch();
        test_reset_midframe();
        test_random_back_to_back();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
